// File: rtl/spi_accel_reader.sv
// rtl/spi_accel_reader.sv - SPI mode-3 accelerometer reader: one config write, then periodic burst reads
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   enable      allows periodic burst reads
//   data        packed axes, axis i in [16i+15:16i]
//   data_update one-cycle strobe when data is refreshed
//   busy        SPI transaction or inter-frame gap in progress
//   overrun     sticky; a sample tick arrived while busy
//   SPI_CSN     chip select, active low
//   SPI_CLK     SCLK, idles high
//   SPI_SDI     MOSI towards the sensor
//   SPI_SDO     MISO from the sensor
module spi_accel_reader #(
    parameter int         CLK_DIV       = 4,
    parameter int         UPDATE_PERIOD = 1000,
    parameter int         NUM_AXES      = 3,
    parameter logic [5:0] START_ADDR    = 6'h32,
    parameter logic [5:0] INIT_ADDR     = 6'h2D,
    parameter logic [7:0] INIT_DATA     = 8'h08
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic [16*NUM_AXES-1:0]  data,
    output logic                    data_update,
    output logic                    busy,
    output logic                    overrun,
    output logic                    SPI_CSN,
    output logic                    SPI_CLK,
    output logic                    SPI_SDI,
    input  logic                    SPI_SDO
);

    localparam int DW      = 16 * NUM_AXES;
    localparam int RD_BITS = 8 + DW;
    localparam int HW      = $clog2(2 * RD_BITS + 2);
    localparam int CW      = $clog2(2 * CLK_DIV);
    localparam int TW      = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;

    localparam logic [CW-1:0] HALF_LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(2 * CLK_DIV - 1);
    localparam logic [HW-1:0] INIT_HP_LAST = HW'(2 * 16 + 1);
    localparam logic [HW-1:0] RD_HP_LAST   = HW'(2 * RD_BITS + 1);
    localparam logic [TW-1:0] TICK_AT      = TW'(UPDATE_PERIOD - 1);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [HW-1:0] hp_q, hp_d;
    logic          is_read_q, is_read_d;
    logic [15:0]   tx_q, tx_d;
    logic [DW-1:0] rx_q, rx_d;
    logic [DW-1:0] data_q, data_d;
    logic          upd_q, upd_d;
    logic          ovr_q, ovr_d;
    logic          csn_q, csn_d;
    logic          sclk_q, sclk_d;
    logic          sdi_q, sdi_d;
    logic          run_q, run_d;
    logic [TW-1:0] tmr_q, tmr_d;

    logic          tick;
    logic          half_end;
    logic [HW-1:0] hp_last;
    logic [DW-1:0] data_map;

    assign tick     = run_q && (tmr_q == TICK_AT);
    assign half_end = (div_q == HALF_LAST);
    assign hp_last  = is_read_q ? RD_HP_LAST : INIT_HP_LAST;

    // rx_q holds the data bytes in arrival order, byte 0 at the top;
    // each axis is little-endian (low byte first on the wire).
    always_comb begin
        data_map = '0;
        for (int i = 0; i < NUM_AXES; i++) begin
            data_map[16*i +: 8]   = rx_q[DW-1-16*i -: 8];
            data_map[16*i+8 +: 8] = rx_q[DW-9-16*i -: 8];
        end
    end

    // Half-period index hp: 0 = setup (high), odd = SCLK low, even = SCLK
    // high, last (odd) = hold with SCLK kept high before CSN rises.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        hp_d      = hp_q;
        is_read_d = is_read_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_d    = data_q;
        upd_d     = 1'b0;
        ovr_d     = ovr_q;
        csn_d     = csn_q;
        sclk_d    = sclk_q;
        sdi_d     = sdi_q;
        run_d     = run_q;
        tmr_d     = tmr_q;

        if (run_q) begin
            tmr_d = tick ? '0 : tmr_q + TW'(1);
        end
        if (tick && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            S_INIT: begin
                tx_d      = {2'b00, INIT_ADDR, INIT_DATA};
                is_read_d = 1'b0;
                state_d   = S_XFER;
                csn_d     = 1'b0;
                div_d     = '0;
                hp_d      = '0;
            end
            S_IDLE: begin
                if (tick && enable) begin
                    tx_d      = {2'b11, START_ADDR, 8'h00};
                    is_read_d = 1'b1;
                    state_d   = S_XFER;
                    csn_d     = 1'b0;
                    div_d     = '0;
                    hp_d      = '0;
                end
            end
            S_XFER: begin
                if (half_end) begin
                    div_d = '0;
                    if (hp_q == hp_last) begin
                        state_d = S_GAP;
                        csn_d   = 1'b1;
                        sdi_d   = 1'b0;
                        if (is_read_q) begin
                            upd_d  = 1'b1;
                            data_d = data_map;
                        end
                    end else begin
                        hp_d = hp_q + HW'(1);
                        if (!hp_q[0] && (hp_q != hp_last - HW'(1))) begin
                            sclk_d = 1'b0;
                            sdi_d  = tx_q[15];
                            tx_d   = {tx_q[14:0], 1'b0};
                        end else if (hp_q[0]) begin
                            // Rising SCLK edge: capture MISO.
                            sclk_d = 1'b1;
                            rx_d   = {rx_q[DW-2:0], SPI_SDO};
                        end
                    end
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            default: begin
                if (div_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    // The tick timer starts from 0 once the config write is done.
                    if (!is_read_q) begin
                        run_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_INIT;
            div_q     <= '0;
            hp_q      <= '0;
            is_read_q <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            data_q    <= '0;
            upd_q     <= 1'b0;
            ovr_q     <= 1'b0;
            csn_q     <= 1'b1;
            sclk_q    <= 1'b1;
            sdi_q     <= 1'b0;
            run_q     <= 1'b0;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            hp_q      <= hp_d;
            is_read_q <= is_read_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_q    <= data_d;
            upd_q     <= upd_d;
            ovr_q     <= ovr_d;
            csn_q     <= csn_d;
            sclk_q    <= sclk_d;
            sdi_q     <= sdi_d;
            run_q     <= run_d;
            tmr_q     <= tmr_d;
        end
    end

    assign data        = data_q;
    assign data_update = upd_q;
    assign busy        = (state_q == S_XFER) || (state_q == S_GAP);
    assign overrun     = ovr_q;
    assign SPI_CSN     = csn_q;
    assign SPI_CLK     = sclk_q;
    assign SPI_SDI     = sdi_q;

endmodule

// File: tb/tb_spi_accel_reader.sv
// tb/tb_spi_accel_reader.sv - self-checking bench for spi_accel_reader
module tb_spi_accel_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst [3];
    logic en  [3];
    logic csn [3];
    logic sclk[3];
    logic sdi [3];
    logic sdo [3] = '{1'b0, 1'b0, 1'b0};
    logic upd [3];
    logic bsy [3];
    logic ovr [3];
    logic [47:0] data_a;
    logic [31:0] data_b;
    logic [47:0] data_c;

    logic [7:0] resp [3][8];

    int n_checks = 0;
    int n_pass   = 0;

    spi_accel_reader u_a (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .data(data_a),
        .data_update(upd[0]), .busy(bsy[0]), .overrun(ovr[0]),
        .SPI_CSN(csn[0]), .SPI_CLK(sclk[0]), .SPI_SDI(sdi[0]), .SPI_SDO(sdo[0])
    );

    spi_accel_reader #(.CLK_DIV(2), .NUM_AXES(2), .UPDATE_PERIOD(400)) u_b (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .data(data_b),
        .data_update(upd[1]), .busy(bsy[1]), .overrun(ovr[1]),
        .SPI_CSN(csn[1]), .SPI_CLK(sclk[1]), .SPI_SDI(sdi[1]), .SPI_SDO(sdo[1])
    );

    spi_accel_reader #(.UPDATE_PERIOD(300)) u_c (
        .clk(clk), .reset(rst[2]), .enable(en[2]), .data(data_c),
        .data_update(upd[2]), .busy(bsy[2]), .overrun(ovr[2]),
        .SPI_CSN(csn[2]), .SPI_CLK(sclk[2]), .SPI_SDI(sdi[2]), .SPI_SDO(sdo[2])
    );

    // Sensor model and bus monitor, one per DUT, all sampled mid-cycle.
    int rises [3]      = '{0, 0, 0};
    int base  [3]      = '{0, 0, 0};
    int frames[3]      = '{0, 0, 0};
    int last_rises[3]  = '{0, 0, 0};
    int updates[3]     = '{0, 0, 0};
    int viol  [3]      = '{0, 0, 0};
    int r0    [3]      = '{0, 0, 0};
    int r1    [3]      = '{0, 0, 0};
    logic [71:0] mosi     [3];
    logic [71:0] last_mosi[3];
    logic pcsn [3] = '{1'b1, 1'b1, 1'b1};
    logic psclk[3] = '{1'b1, 1'b1, 1'b1};

    function automatic logic slave_bit(int g, int n);
        int k;
        logic [7:0] b;
        if (n < 8) return 1'b0;
        k = n - 8;
        if (k / 8 >= 8) return 1'b0;
        b = resp[g][k/8];
        return b[7 - k % 8];
    endfunction

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (csn[g] === 1'b0 && pcsn[g] === 1'b1) begin
                base[g] <= rises[g];
                mosi[g] <= '0;
            end
            if (csn[g] === 1'b0 && sclk[g] === 1'b0 && psclk[g] === 1'b1)
                sdo[g] <= slave_bit(g, rises[g] - base[g]);
            if (csn[g] === 1'b0 && sclk[g] === 1'b1 && psclk[g] === 1'b0) begin
                if (rises[g] - base[g] == 0) r0[g] <= cyc;
                if (rises[g] - base[g] == 1) r1[g] <= cyc;
                mosi[g]  <= {mosi[g][70:0], sdi[g]};
                rises[g] <= rises[g] + 1;
            end
            if (csn[g] === 1'b1 && pcsn[g] === 1'b0) begin
                frames[g]     <= frames[g] + 1;
                last_rises[g] <= rises[g] - base[g];
                last_mosi[g]  <= mosi[g];
            end
            if (upd[g] === 1'b1) updates[g] <= updates[g] + 1;
            if (csn[g] === 1'b1 && sclk[g] === 1'b0) viol[g] <= viol[g] + 1;
            pcsn[g]  <= csn[g];
            psclk[g] <= sclk[g];
        end
    end

    // Expected packed axes: axis i = byte[2i+1]*256 + byte[2i].
    function automatic logic [63:0] exp_data(int g, int naxes);
        logic [63:0] v = '0;
        for (int i = 0; i < naxes; i++)
            v += 64'(int'(resp[g][2*i+1]) * 256 + int'(resp[g][2*i])) << (16 * i);
        return v;
    endfunction

    task automatic fill_resp(int g);
        for (int i = 0; i < 8; i++) resp[g][i] = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_csn(input int g, input logic lvl, input int limit, output int waited);
        waited = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (csn[g] === lvl) begin waited = i; break; end
        end
    endtask

    task automatic wait_upd(input int g, input int limit, output int waited);
        waited = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (upd[g] === 1'b1) begin waited = i; break; end
        end
    endtask

    task automatic wait_rises(input int g, input int n, input int limit, output int waited);
        waited = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            #1;
            if (rises[g] - base[g] >= n) begin waited = i; break; end
        end
    endtask

    task automatic test_reset();
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if ({csn[g], sclk[g], sdi[g], upd[g], bsy[g], ovr[g]} !== 6'b110000)
                $display("FAIL reset_outputs[%0d]: got %b want 110000", g,
                         {csn[g], sclk[g], sdi[g], upd[g], bsy[g], ovr[g]});
            else n_pass++;
        end
        n_checks++;
        if (data_a !== 48'h0 || data_b !== 32'h0 || data_c !== 48'h0)
            $display("FAIL reset_data: got %h %h %h want 0", data_a, data_b, data_c);
        else n_pass++;
    endtask

    task automatic test_init_write();
        int w, u0;
        u0 = updates[0];
        rst[0] = 1'b0;
        wait_csn(0, 1'b0, 20, w);
        n_checks++;
        if (w < 0) $display("FAIL init_csn_fall: got timeout want fall"); else n_pass++;
        wait_csn(0, 1'b1, 400, w);
        n_checks++;
        if (w < 0) $display("FAIL init_csn_rise: got timeout want rise"); else n_pass++;
        #1;
        n_checks++;
        if (last_rises[0] !== 16) $display("FAIL init_sclk_count: got %0d want 16", last_rises[0]);
        else n_pass++;
        n_checks++;
        if (last_mosi[0][15:0] !== 16'h2D08)
            $display("FAIL init_mosi: got %h want 2d08", last_mosi[0][15:0]);
        else n_pass++;
        n_checks++;
        if (r1[0] - r0[0] !== 8) $display("FAIL init_sclk_period: got %0d want 8", r1[0] - r0[0]);
        else n_pass++;
        repeat (20) @(negedge clk);
        n_checks++;
        if (updates[0] !== u0) $display("FAIL init_no_update: got %0d want %0d", updates[0], u0);
        else n_pass++;
        n_checks++;
        if (viol[0] !== 0) $display("FAIL sclk_idle_high: got %0d want 0", viol[0]);
        else n_pass++;
    endtask

    task automatic test_read();
        int w, f;
        logic [63:0] e;
        for (int t = 0; t < 3; t++) begin
            if (t == 0) begin
                resp[0][0] = 8'h34; resp[0][1] = 8'h12; resp[0][2] = 8'h78;
                resp[0][3] = 8'h56; resp[0][4] = 8'hBC; resp[0][5] = 8'h9A;
            end else fill_resp(0);
            e = exp_data(0, 3);
            en[0] = 1'b1;
            wait_csn(0, 1'b0, 1200, w);
            f = cyc;
            n_checks++;
            if (w < 0) $display("FAIL read_csn_fall[%0d]: got timeout want fall", t); else n_pass++;
            wait_upd(0, 600, w);
            n_checks++;
            if (cyc - f !== 456) $display("FAIL read_latency[%0d]: got %0d want 456", t, cyc - f);
            else n_pass++;
            n_checks++;
            if (csn[0] !== 1'b1) $display("FAIL update_with_csn_rise[%0d]: got %b want 1", t, csn[0]);
            else n_pass++;
            n_checks++;
            if (data_a !== e[47:0]) $display("FAIL read_data[%0d]: got %h want %h", t, data_a, e[47:0]);
            else n_pass++;
            #1;
            n_checks++;
            if (last_mosi[0][55:0] !== 56'hF2_0000_0000_0000 || last_rises[0] !== 56)
                $display("FAIL read_cmd[%0d]: got %h/%0d want f2000000000000/56", t,
                         last_mosi[0][55:0], last_rises[0]);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (upd[0] !== 1'b0 || data_a !== e[47:0])
                $display("FAIL update_one_cycle[%0d]: got %b %h want 0 %h", t, upd[0], data_a, e[47:0]);
            else n_pass++;
        end
        n_checks++;
        if (ovr[0] !== 1'b0) $display("FAIL read_no_overrun: got %b want 0", ovr[0]); else n_pass++;
    endtask

    task automatic test_small_config();
        int w, f;
        logic [63:0] e;
        fill_resp(1);
        e = exp_data(1, 2);
        en[1]  = 1'b1;
        rst[1] = 1'b0;
        wait_csn(1, 1'b0, 20, w);
        wait_csn(1, 1'b1, 200, w);
        #1;
        n_checks++;
        if (last_rises[1] !== 16 || updates[1] !== 0)
            $display("FAIL small_init: got %0d/%0d want 16/0", last_rises[1], updates[1]);
        else n_pass++;
        wait_csn(1, 1'b0, 600, w);
        f = cyc;
        wait_upd(1, 300, w);
        n_checks++;
        if (w < 0 || cyc - f !== 164) $display("FAIL small_latency: got %0d want 164", cyc - f);
        else n_pass++;
        n_checks++;
        if (data_b !== e[31:0]) $display("FAIL small_data: got %h want %h", data_b, e[31:0]);
        else n_pass++;
        #1;
        n_checks++;
        if (last_rises[1] !== 40 || last_mosi[1][39:0] !== 40'hF2_0000_0000)
            $display("FAIL small_frame: got %0d/%h want 40/f200000000", last_rises[1], last_mosi[1][39:0]);
        else n_pass++;
        n_checks++;
        if (r1[1] - r0[1] !== 4) $display("FAIL small_sclk_period: got %0d want 4", r1[1] - r0[1]);
        else n_pass++;
    endtask

    task automatic test_overrun();
        int w, f, f2;
        logic [63:0] e;
        fill_resp(2);
        e = exp_data(2, 3);
        en[2]  = 1'b1;
        rst[2] = 1'b0;
        wait_csn(2, 1'b0, 20, w);
        wait_csn(2, 1'b1, 400, w);
        wait_csn(2, 1'b0, 400, w);
        f = cyc;
        n_checks++;
        if (w < 0 || ovr[2] !== 1'b0) $display("FAIL ovr_before: got %b want 0", ovr[2]); else n_pass++;
        w = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ovr[2] === 1'b1) begin w = i; break; end
        end
        n_checks++;
        if (w < 0 || cyc - f !== 300) $display("FAIL ovr_rise_time: got %0d want 300", cyc - f);
        else n_pass++;
        wait_upd(2, 600, w);
        n_checks++;
        if (w < 0 || data_c !== e[47:0]) $display("FAIL ovr_read_data: got %h want %h", data_c, e[47:0]);
        else n_pass++;
        fill_resp(2);
        e = exp_data(2, 3);
        wait_csn(2, 1'b0, 800, w);
        f2 = cyc;
        n_checks++;
        if (w < 0 || f2 - f !== 600) $display("FAIL ovr_read_spacing: got %0d want 600", f2 - f);
        else n_pass++;
        wait_upd(2, 600, w);
        n_checks++;
        if (w < 0 || data_c !== e[47:0]) $display("FAIL ovr_read_data2: got %h want %h", data_c, e[47:0]);
        else n_pass++;
        n_checks++;
        if (ovr[2] !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", ovr[2]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int w;
        fill_resp(0);
        en[0] = 1'b1;
        wait_csn(0, 1'b0, 1200, w);
        wait_rises(0, 20, 400, w);
        repeat (5) @(negedge clk);
        n_checks++;
        if (w < 0 || sclk[0] !== 1'b0 || csn[0] !== 1'b0)
            $display("FAIL mid_precondition: got %b%b want 00", csn[0], sclk[0]);
        else n_pass++;
        rst[0] = 1'b1;
        #1;
        n_checks++;
        if ({csn[0], sclk[0], upd[0], bsy[0]} !== 4'b1100 || data_a !== 48'h0)
            $display("FAIL mid_reset_async: got %b %h want 1100 0", {csn[0], sclk[0], upd[0], bsy[0]}, data_a);
        else n_pass++;
        @(negedge clk);
        rst[0] = 1'b0;
        wait_csn(0, 1'b0, 20, w);
        wait_csn(0, 1'b1, 400, w);
        #1;
        n_checks++;
        if (w < 0 || last_rises[0] !== 16 || last_mosi[0][15:0] !== 16'h2D08)
            $display("FAIL mid_reinit: got %0d/%h want 16/2d08", last_rises[0], last_mosi[0][15:0]);
        else n_pass++;
    endtask

    task automatic test_enable_drop();
        int w, fr, u;
        logic [63:0] e;
        fill_resp(0);
        e = exp_data(0, 3);
        wait_csn(0, 1'b0, 1200, w);
        wait_rises(0, 10, 200, w);
        en[0] = 1'b0;
        wait_upd(0, 600, w);
        n_checks++;
        if (w < 0 || data_a !== e[47:0]) $display("FAIL drop_read_data: got %h want %h", data_a, e[47:0]);
        else n_pass++;
        #1;
        fr = frames[0];
        u  = updates[0];
        repeat (3000) @(negedge clk);
        #1;
        n_checks++;
        if (frames[0] !== fr || updates[0] !== u)
            $display("FAIL drop_no_activity: got %0d/%0d want %0d/%0d", frames[0], updates[0], fr, u);
        else n_pass++;
        n_checks++;
        if (ovr[0] !== 1'b0 || csn[0] !== 1'b1)
            $display("FAIL drop_idle_state: got %b%b want 01", ovr[0], csn[0]);
        else n_pass++;
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst[g] = 1'b1;
            en[g]  = 1'b0;
            for (int i = 0; i < 8; i++) resp[g][i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_init_write();
        test_read();
        test_small_config();
        test_overrun();
        test_reset_mid();
        test_enable_drop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
